// File: rtl/branch_predictor_gshare_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare_if
//   Bundles the request, result and update channels of the gshare predictor.
//   master : the fetch/execute pipeline (drives requests and resolve updates)
//   slave  : the predictor itself
//
//   Handshake: valid-only, no ready. A request (pred_valid_i) and an update
//   (upd_valid_i) are each consumed on every rising clk edge where they are 1;
//   the predictor never stalls. pred_valid_o is asserted for exactly one cycle,
//   one edge after the request was sampled.
// -----------------------------------------------------------------------------
interface branch_predictor_gshare_if #(
   parameter int PC_W   = 32,
   parameter int IDX_W  = 5,
   parameter int HIST_W = 5
);
   logic              pred_valid_i;
   logic [PC_W-1:0]   pred_pc_i;
   logic              pred_valid_o;
   logic              pred_taken_o;
   logic [IDX_W-1:0]  pred_idx_o;
   logic [HIST_W-1:0] pred_ghr_o;
   logic              upd_valid_i;
   logic [IDX_W-1:0]  upd_idx_i;
   logic [HIST_W-1:0] upd_ghr_i;
   logic              upd_taken_i;
   logic              upd_mispred_i;
   logic [HIST_W-1:0] ghr_o;

   modport master (
      output pred_valid_i, pred_pc_i,
      output upd_valid_i, upd_idx_i, upd_ghr_i, upd_taken_i, upd_mispred_i,
      input  pred_valid_o, pred_taken_o, pred_idx_o, pred_ghr_o, ghr_o
   );

   modport slave (
      input  pred_valid_i, pred_pc_i,
      input  upd_valid_i, upd_idx_i, upd_ghr_i, upd_taken_i, upd_mispred_i,
      output pred_valid_o, pred_taken_o, pred_idx_o, pred_ghr_o, ghr_o
   );
endinterface

// File: rtl/branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare
//   Pattern history table of 2^IDX_W saturating CNT_W-bit counters, indexed by
//   PC bits optionally XORed with a global history register (gshare). The GHR
//   is shifted speculatively on each prediction and repaired from the carried
//   snapshot on a mispredict. Predictions have a latency of one cycle.
//
// Ports
//   clk     : rising-edge clock
//   arst_n  : asynchronous active-low reset
//   bus     : slave side of branch_predictor_gshare_if
//               pred_valid_i/pred_pc_i            request from IF
//               pred_valid_o/taken/idx/ghr        registered prediction
//               upd_valid_i/idx/ghr/taken/mispred resolve from EX
//               ghr_o                             current GHR (debug/perf)
// -----------------------------------------------------------------------------
module branch_predictor_gshare #(
   parameter int PC_W    = 32,
   parameter int PC_LSB  = 2,
   parameter int IDX_W   = 5,
   parameter int CNT_W   = 2,
   parameter int HIST_W  = 5,
   parameter int USE_GHR = 1
) (
   input logic                     clk,
   input logic                     arst_n,
   branch_predictor_gshare_if.slave bus
);

   localparam int DEPTH = 1 << IDX_W;
   // Weakly not-taken: MSB clear, all lower bits set (0 when CNT_W=1).
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [CNT_W-1:0]  pht [DEPTH];
   logic [HIST_W-1:0] ghr;

   logic              pred_valid_q;
   logic              pred_taken_q;
   logic [IDX_W-1:0]  pred_idx_q;
   logic [HIST_W-1:0] pred_ghr_q;

   logic [IDX_W-1:0]  pc_idx;
   logic [IDX_W-1:0]  req_idx;
   logic [CNT_W-1:0]  upd_cur;
   logic [CNT_W-1:0]  upd_cnt_next;
   logic [CNT_W-1:0]  rd_cnt;
   logic              req_taken;
   logic              unused_pc_bits;

   // Shift a bit into the history; for HIST_W=1 the result is just the bit.
   function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h,
                                                   input logic b);
      return (h << 1) | HIST_W'(b);
   endfunction

   assign pc_idx  = bus.pred_pc_i[PC_LSB+IDX_W-1:PC_LSB];
   assign req_idx = (USE_GHR != 0) ? (pc_idx ^ IDX_W'(ghr)) : pc_idx;

   assign unused_pc_bits = ^{bus.pred_pc_i[PC_W-1:PC_LSB+IDX_W],
                             bus.pred_pc_i[PC_LSB-1:0]};

   // Saturating next value for the entry being updated.
   always_comb begin
      upd_cur      = pht[bus.upd_idx_i];
      upd_cnt_next = upd_cur;
      if (bus.upd_taken_i) begin
         if (upd_cur != CNT_MAX) upd_cnt_next = upd_cur + CNT_W'(1);
      end else begin
         if (upd_cur != '0) upd_cnt_next = upd_cur - CNT_W'(1);
      end
   end

   // A same-cycle update to the requested entry is forwarded to the read.
   assign rd_cnt    = (bus.upd_valid_i && (bus.upd_idx_i == req_idx))
                      ? upd_cnt_next : pht[req_idx];
   assign req_taken = rd_cnt[CNT_W-1];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_INIT;
         ghr          <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_idx_q   <= '0;
         pred_ghr_q   <= '0;
      end else begin
         if (bus.upd_valid_i) pht[bus.upd_idx_i] <= upd_cnt_next;

         pred_valid_q <= bus.pred_valid_i;
         if (bus.pred_valid_i) begin
            pred_taken_q <= req_taken;
            pred_idx_q   <= req_idx;
            pred_ghr_q   <= ghr;
         end

         // Repair wins over the speculative shift of a same-cycle request.
         if (bus.upd_valid_i && bus.upd_mispred_i)
            ghr <= shift_in(bus.upd_ghr_i, bus.upd_taken_i);
         else if (bus.pred_valid_i)
            ghr <= shift_in(ghr, req_taken);
      end
   end

   assign bus.pred_valid_o = pred_valid_q;
   assign bus.pred_taken_o = pred_taken_q;
   assign bus.pred_idx_o   = pred_idx_q;
   assign bus.pred_ghr_o   = pred_ghr_q;
   assign bus.ghr_o        = ghr;

endmodule
